// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: display fetches (320x240 doubled to 640x480) have
// absolute priority, host accesses take the remaining eligible cycles.
module vga_fb_arbiter #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 17,
    parameter int unsigned FB_W     = 320,
    parameter int unsigned FB_WORDS = 76800
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_tick,
    input  logic              video_on,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              vblank_only,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_ack,
    output logic [DATA_W-1:0] h_rdata,
    output logic              h_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic [15:0]       stall_max
);

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_DISP,
        TAG_HREAD,
        TAG_HREAD_OOR
    } tag_e;

    tag_e              tag_q, tag_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] pix_q;
    logic [DATA_W-1:0] rdata_q;
    logic [15:0]       wait_q, wait_d;
    logic [15:0]       smax_q, smax_d;
    logic              disp_slot;
    logic              host_ok;
    logic              grant;
    logic              h_oor;

    assign disp_slot = p_tick && video_on && !x[0];
    assign disp_addr = ADDR_W'(y[9:1]) * ADDR_W'(FB_W) + ADDR_W'(x[9:1]);
    assign host_ok   = !reset && !disp_slot && (!vblank_only || (y >= 10'd480));
    assign grant     = h_req && host_ok;
    assign h_oor     = h_addr >= ADDR_W'(FB_WORDS);

    // RAM command mux; idle cycles keep the previous address on the bus
    always_comb begin
        mem_addr  = addr_q;
        mem_we    = 1'b0;
        mem_wdata = h_wdata;
        h_ack     = 1'b0;
        tag_d     = TAG_NONE;
        if (reset) begin
            mem_addr = '0;
        end else if (disp_slot) begin
            mem_addr = disp_addr;
            tag_d    = TAG_DISP;
        end else if (grant) begin
            mem_addr = h_addr;
            mem_we   = h_we && !h_oor;
            h_ack    = 1'b1;
            if (!h_we) begin
                tag_d = h_oor ? TAG_HREAD_OOR : TAG_HREAD;
            end
        end
    end

    // Read return steered by what the previous cycle issued
    always_comb begin
        h_rvalid = !reset && ((tag_q == TAG_HREAD) || (tag_q == TAG_HREAD_OOR));
        h_rdata  = rdata_q;
        if (!reset && (tag_q == TAG_HREAD)) begin
            h_rdata = mem_rdata;
        end else if (!reset && (tag_q == TAG_HREAD_OOR)) begin
            h_rdata = '0;
        end
    end

    always_comb begin
        wait_d = '0;
        if (h_req && !h_ack) begin
            wait_d = (wait_q == 16'hFFFF) ? wait_q : wait_q + 16'd1;
        end
        smax_d = (wait_q > smax_q) ? wait_q : smax_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q   <= TAG_NONE;
            addr_q  <= '0;
            pix_q   <= '0;
            rdata_q <= '0;
            wait_q  <= '0;
            smax_q  <= '0;
        end else begin
            tag_q   <= tag_d;
            addr_q  <= mem_addr;
            if (tag_q == TAG_DISP) begin
                pix_q <= mem_rdata;
            end
            rdata_q <= h_rdata;
            wait_q  <= wait_d;
            smax_q  <= smax_d;
        end
    end

    assign pix_data  = pix_q;
    assign stall_max = smax_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: RAM model, directed scan/host scenarios and a
// per-cycle behavioural model with its own shadow framebuffer.
module tb_vga_fb_arbiter;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 17;
    localparam int unsigned FB_W     = 320;
    localparam int unsigned FB_WORDS = 76800;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, p_tick, video_on, vblank_only;
    logic [9:0]        x, y;
    logic              h_req, h_we, h_ack, h_rvalid, mem_we;
    logic [ADDR_W-1:0] h_addr, mem_addr;
    logic [DATA_W-1:0] h_wdata, h_rdata, mem_wdata, mem_rdata, pix_data;
    logic [15:0]       stall_max;

    vga_fb_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FB_W(FB_W), .FB_WORDS(FB_WORDS)
    ) dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
        .x(x), .y(y), .vblank_only(vblank_only),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_ack(h_ack), .h_rdata(h_rdata), .h_rvalid(h_rvalid),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .pix_data(pix_data), .stall_max(stall_max)
    );

    // Synchronous single-port RAM, preloaded with addr[7:0]
    logic [7:0] ram [FB_WORDS];
    bit         loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < int'(FB_WORDS); i++) ram[i] <= 8'(i);
            loaded <= 1'b1;
        end else if (mem_we && (int'(mem_addr) < int'(FB_WORDS))) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= (int'(mem_addr) < int'(FB_WORDS)) ? ram[mem_addr] : 8'hEE;
    end

    int checks = 0;
    int errs   = 0;

    // Model state: what each output must show in the current cycle
    logic [7:0] shadow [FB_WORDS];
    int m_addr_last = 0, m_pix = 0, m_rdata = 0, m_smax = 0, m_wait = 0;
    bit m_disp_ret = 0, m_rd_ret = 0;
    int m_disp_val = 0, m_rd_val = 0;

    int  sx, sy;
    bit  sph, jmp;
    int  jx, jy;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_cycle();
        bit slot, ack, oor, we;
        int a;
        slot = !reset && p_tick && video_on && !x[0];
        ack  = !reset && h_req && !slot && (!vblank_only || (int'(y) >= 480));
        oor  = int'(h_addr) >= int'(FB_WORDS);
        if (reset)     a = 0;
        else if (slot) a = int'(y >> 1) * int'(FB_W) + int'(x >> 1);
        else if (ack)  a = int'(h_addr);
        else           a = m_addr_last;
        we = ack && h_we && !oor;
        cmp("h_ack", int'(h_ack), int'(ack));
        cmp("mem_we", int'(mem_we), int'(we));
        cmp("mem_addr", int'(mem_addr), a);
        if (we) cmp("mem_wdata", int'(mem_wdata), int'(h_wdata));
        cmp("h_rvalid", int'(h_rvalid), int'(!reset && m_rd_ret));
        if (!reset) begin
            if (m_rd_ret) m_rdata = m_rd_val;
            cmp("h_rdata", int'(h_rdata), m_rdata);
        end
        cmp("pix_data", int'(pix_data), m_pix);
        cmp("stall_max", int'(stall_max), m_smax);
        if (reset) begin
            m_addr_last = 0; m_pix = 0; m_rdata = 0; m_smax = 0; m_wait = 0;
            m_disp_ret = 0; m_rd_ret = 0;
        end else begin
            if (m_disp_ret) m_pix = m_disp_val;
            if (m_wait > m_smax) m_smax = m_wait;
            if (h_req && !ack) m_wait = (m_wait >= 65535) ? 65535 : m_wait + 1;
            else               m_wait = 0;
            m_disp_ret = slot;
            m_disp_val = slot ? int'(shadow[a]) : 0;
            m_rd_ret   = ack && !h_we;
            m_rd_val   = oor ? 0 : int'(shadow[int'(h_addr)]);
            if (we) shadow[int'(h_addr)] = h_wdata;
            m_addr_last = a;
        end
    endtask

    // Finish the current cycle (compare), then start the next with the sync counters advanced
    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        if (jmp) begin
            sx = jx; sy = jy; sph = 1'b1; jmp = 1'b0;
        end else if (sph) begin
            sph = 1'b0;
        end else begin
            sph = 1'b1;
            sx++;
            if (sx == 800) begin
                sx = 0;
                sy = (sy == 524) ? 0 : sy + 1;
            end
        end
        x = 10'(sx); y = 10'(sy); p_tick = sph;
        video_on = (sx < 640) && (sy < 480);
    endtask

    task automatic jump(input int nx, input int ny);
        jx = nx; jy = ny; jmp = 1'b1;
        tick();
    endtask

    task automatic host_op(input bit we, input int addr, input int data,
                           output int waited, output int a_addr, output int a_we);
        bit got;
        got = 1'b0; waited = 0; a_addr = -1; a_we = -1;
        h_req = 1'b1; h_we = we; h_addr = ADDR_W'(addr); h_wdata = 8'(data);
        for (int i = 0; i < 200 && !got; i++) begin
            #1;
            if (h_ack) begin
                got = 1'b1; a_addr = int'(mem_addr); a_we = int'(mem_we);
            end else begin
                waited++;
            end
            tick();
        end
        h_req = 1'b0;
        cmp("host_ack_seen", int'(got), 1);
    endtask

    int w, aa, awe;
    bit got5;

    initial begin
        for (int i = 0; i < int'(FB_WORDS); i++) shadow[i] = 8'(i);
        reset = 1'b1; vblank_only = 1'b0;
        h_req = 1'b1; h_we = 1'b1; h_addr = 17'd5; h_wdata = 8'h33;
        sx = 700; sy = 500; sph = 1'b0; jmp = 1'b0;
        x = 10'(sx); y = 10'(sy); p_tick = 1'b0; video_on = 1'b0;
        @(posedge clk); #1;

        // Reset: grant blocked even with an eligible request
        tick(); tick();
        #1;
        cmp("rst_ack_blocked", int'(h_ack), 0);
        cmp("rst_mem_we", int'(mem_we), 0);
        tick();
        reset = 1'b0; h_req = 1'b0;
        #1;
        cmp("rst_pix", int'(pix_data), 0);
        cmp("rst_stall", int'(stall_max), 0);
        cmp("rst_rvalid", int'(h_rvalid), 0);

        // Idle scan fetch at x=10, y=3
        jump(10, 3);
        #1;
        cmp("scan_addr", int'(mem_addr), 325);
        tick(); tick();
        #1;
        cmp("scan_pix0", int'(pix_data), 8'h45);
        for (int i = 1; i < 4; i++) begin
            tick();
            #1;
            cmp("scan_pix_hold", int'(pix_data), 8'h45);
        end

        // Host write raised on a display slot: acked one cycle later
        jump(20, 50);
        host_op(1'b1, 1000, 8'hA5, w, aa, awe);
        cmp("wr_wait", w, 1);
        cmp("wr_mem_addr", aa, 1000);
        cmp("wr_mem_we", awe, 1);
        jump(80, 6);
        tick(); tick();
        #1;
        cmp("wr_readback_pix", int'(pix_data), 8'hA5);

        // Host read of the last word, then out-of-range accesses
        jump(700, 50);
        host_op(1'b0, 76799, 0, w, aa, awe);
        #1;
        cmp("rd_rvalid", int'(h_rvalid), 1);
        cmp("rd_rdata", int'(h_rdata), 8'hFF);
        host_op(1'b1, 76800, 8'h11, w, aa, awe);
        cmp("oor_wr_mem_we", awe, 0);
        host_op(1'b0, 80000, 0, w, aa, awe);
        #1;
        cmp("oor_rd_rvalid", int'(h_rvalid), 1);
        cmp("oor_rd_rdata", int'(h_rdata), 0);

        // vblank_only: held off through active video until y reaches 480
        vblank_only = 1'b1;
        jump(100, 100);
        h_req = 1'b1; h_we = 1'b0; h_addr = 17'd1000;
        w = 0; got5 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            cmp("vb_no_ack", int'(h_ack), 0);
            w++;
            tick();
        end
        jx = 795; jy = 479; jmp = 1'b1;
        for (int i = 0; i < 100 && !got5; i++) begin
            #1;
            if (h_ack) begin
                got5 = 1'b1;
                cmp("vb_grant_y", int'(y), 480);
                cmp("vb_grant_x", int'(x), 0);
            end else begin
                w++;
                tick();
            end
        end
        cmp("vb_ack_seen", int'(got5), 1);
        tick();
        h_req = 1'b0;
        #1;
        cmp("vb_rvalid", int'(h_rvalid), 1);
        cmp("vb_rdata", int'(h_rdata), 8'hA5);
        cmp("vb_stall_max", int'(stall_max), w);

        // Reset the cycle after a host read ack
        vblank_only = 1'b0;
        jump(30, 20);
        repeat (4) tick();
        host_op(1'b0, 325, 0, w, aa, awe);
        reset = 1'b1;
        #1;
        cmp("mid_rst_rvalid", int'(h_rvalid), 0);
        tick();
        reset = 1'b0;
        #1;
        cmp("post_rst_rvalid", int'(h_rvalid), 0);
        cmp("post_rst_pix", int'(pix_data), 0);
        cmp("post_rst_stall", int'(stall_max), 0);
        jump(10, 3);
        #1;
        cmp("resume_addr", int'(mem_addr), 325);
        tick(); tick();
        #1;
        cmp("resume_pix", int'(pix_data), 8'h45);
        repeat (8) tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
